// File: rtl/dual_fetch_unit_if.sv
// Instruction-memory bus between the dual fetch unit and a two-port,
// combinational-read instruction memory.
interface dual_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned INST_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr0;
  logic [ADDR_WIDTH-1:0] imem_addr1;
  logic [INST_WIDTH-1:0] imem_data0;
  logic [INST_WIDTH-1:0] imem_data1;

  modport master (
    output imem_addr0,
    output imem_addr1,
    input  imem_data0,
    input  imem_data1
  );

  modport slave (
    input  imem_addr0,
    input  imem_addr1,
    output imem_data0,
    output imem_data1
  );
endinterface

// File: rtl/dual_fetch_unit.sv
// Dual-issue fetch stage with IF/ID slot pair, driven by per-pipe hazard
// stall/flush masks and an EX branch redirect.
module dual_fetch_unit #(
  parameter int unsigned      ADDR_WIDTH         = 16,
  parameter int unsigned      INST_WIDTH         = 32,
  parameter int unsigned      NUM_PIPE_MASKS     = 4,
  parameter int unsigned      PIPE_REG_PC        = 0,
  parameter int unsigned      PIPE_REG_IF_ID     = 1,
  parameter int unsigned      OP_CODE_BITS       = 6,
  parameter int unsigned      NUM_REGISTERS_LOG2 = 5,
  parameter logic [5:0]       OP_CODE_NOP        = 6'h3F
) (
  input  logic                          clk,
  input  logic                          reset,
  dual_fetch_unit_if.master             imem,
  input  logic [NUM_PIPE_MASKS-1:0]     stall0,
  input  logic [NUM_PIPE_MASKS-1:0]     stall1,
  input  logic [NUM_PIPE_MASKS-1:0]     flush0,
  input  logic [NUM_PIPE_MASKS-1:0]     flush1,
  input  logic                          branch_taken,
  input  logic [ADDR_WIDTH-1:0]         branch_target,
  output logic [ADDR_WIDTH-1:0]         pc,
  output logic [INST_WIDTH-1:0]         if_id_instr0,
  output logic [INST_WIDTH-1:0]         if_id_instr1,
  output logic [ADDR_WIDTH-1:0]         if_id_pc0,
  output logic [ADDR_WIDTH-1:0]         if_id_pc1,
  output logic                          if_id_valid0,
  output logic                          if_id_valid1,
  output logic [OP_CODE_BITS-1:0]       if_id_opcode0,
  output logic [OP_CODE_BITS-1:0]       if_id_opcode1,
  output logic [NUM_REGISTERS_LOG2-1:0] if_id_rs0,
  output logic [NUM_REGISTERS_LOG2-1:0] if_id_rs1,
  output logic [NUM_REGISTERS_LOG2-1:0] if_id_rt0,
  output logic [NUM_REGISTERS_LOG2-1:0] if_id_rt1,
  output logic [NUM_REGISTERS_LOG2-1:0] if_id_rd0,
  output logic [NUM_REGISTERS_LOG2-1:0] if_id_rd1,
  output logic                          first
);

  localparam logic [INST_WIDTH-1:0] NOP_WORD =
    {OP_CODE_NOP[OP_CODE_BITS-1:0], {(INST_WIDTH-OP_CODE_BITS){1'b0}}};

  logic hold0, hold1, kill0, kill1;
  logic [ADDR_WIDTH-1:0] pc_plus1;

  assign hold0    = stall0[PIPE_REG_IF_ID];
  assign hold1    = stall1[PIPE_REG_IF_ID];
  assign kill0    = flush0[PIPE_REG_IF_ID];
  assign kill1    = flush1[PIPE_REG_IF_ID];
  assign pc_plus1 = pc + ADDR_WIDTH'(1);

  // PC-register mask bits are implied by the IF/ID bits; only the IF/ID bits steer state.
  logic unused_mask_bits;
  assign unused_mask_bits = ^{stall0, stall1, flush0, flush1};

  assign imem.imem_addr0 = pc;
  assign imem.imem_addr1 = pc_plus1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= '0;
      first        <= 1'b0;
      if_id_instr0 <= NOP_WORD;
      if_id_instr1 <= NOP_WORD;
      if_id_pc0    <= '0;
      if_id_pc1    <= '0;
      if_id_valid0 <= 1'b0;
      if_id_valid1 <= 1'b0;
    end else if (branch_taken) begin
      pc           <= branch_target;
      first        <= 1'b0;
      if_id_instr0 <= NOP_WORD;
      if_id_instr1 <= NOP_WORD;
      if_id_pc0    <= '0;
      if_id_pc1    <= '0;
      if_id_valid0 <= 1'b0;
      if_id_valid1 <= 1'b0;
    end else if (hold0 && hold1) begin
      // load-use stall: everything keeps its value
    end else if (hold0 && kill1) begin
      // slot 0 held keeps the older instruction; slot 1 takes the next one
      if_id_instr1 <= imem.imem_data0;
      if_id_pc1    <= pc;
      if_id_valid1 <= 1'b1;
      pc           <= pc_plus1;
      first        <= 1'b0;
    end else if (hold1 && kill0) begin
      if_id_instr0 <= imem.imem_data0;
      if_id_pc0    <= pc;
      if_id_valid0 <= 1'b1;
      pc           <= pc_plus1;
      first        <= 1'b1;
    end else if (!hold0 && !hold1 && !kill0 && !kill1) begin
      if_id_instr0 <= imem.imem_data0;
      if_id_instr1 <= imem.imem_data1;
      if_id_pc0    <= pc;
      if_id_pc1    <= pc_plus1;
      if_id_valid0 <= 1'b1;
      if_id_valid1 <= 1'b1;
      pc           <= pc + ADDR_WIDTH'(2);
      first        <= 1'b0;
    end else begin
      first        <= 1'b0;
      if_id_instr0 <= NOP_WORD;
      if_id_instr1 <= NOP_WORD;
      if_id_pc0    <= '0;
      if_id_pc1    <= '0;
      if_id_valid0 <= 1'b0;
      if_id_valid1 <= 1'b0;
    end
  end

  assign if_id_opcode0 = if_id_instr0[31:26];
  assign if_id_opcode1 = if_id_instr1[31:26];
  assign if_id_rs0     = if_id_instr0[25:21];
  assign if_id_rs1     = if_id_instr1[25:21];
  assign if_id_rt0     = if_id_instr0[20:16];
  assign if_id_rt1     = if_id_instr1[20:16];
  assign if_id_rd0     = if_id_instr0[15:11];
  assign if_id_rd1     = if_id_instr1[15:11];

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Directed, table-driven bench for dual_fetch_unit with a small imem model
// (imem[i] = i + 0x100) and a switchable pair of field-decode words.
module tb_dual_fetch_unit;

  localparam logic [31:0] NOP = 32'hFC00_0000;
  localparam logic [3:0]  PI  = 4'b0011;   // PC | IF_ID
  localparam logic [3:0]  IF  = 4'b0010;   // IF_ID only
  localparam logic [3:0]  PCB = 4'b0001;   // PC only

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  stall0, stall1, flush0, flush1;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc, if_id_pc0, if_id_pc1;
  logic [31:0] if_id_instr0, if_id_instr1;
  logic        if_id_valid0, if_id_valid1, first;
  logic [5:0]  if_id_opcode0, if_id_opcode1;
  logic [4:0]  if_id_rs0, if_id_rs1, if_id_rt0, if_id_rt1, if_id_rd0, if_id_rd1;

  logic        alt = 1'b0;
  logic [31:0] alt_w0 = 32'h8C43_2800;
  logic [31:0] alt_w1 = 32'h0128_5020;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dual_fetch_unit_if #(.ADDR_WIDTH(16), .INST_WIDTH(32)) bus ();

  assign bus.imem_data0 = alt ? alt_w0 : ({16'h0, bus.imem_addr0} + 32'h100);
  assign bus.imem_data1 = alt ? alt_w1 : ({16'h0, bus.imem_addr1} + 32'h100);

  dual_fetch_unit #(
    .ADDR_WIDTH(16), .INST_WIDTH(32), .NUM_PIPE_MASKS(4), .PIPE_REG_PC(0),
    .PIPE_REG_IF_ID(1), .OP_CODE_BITS(6), .NUM_REGISTERS_LOG2(5), .OP_CODE_NOP(6'h3F)
  ) dut (
    .clk(clk), .reset(reset), .imem(bus.master),
    .stall0(stall0), .stall1(stall1), .flush0(flush0), .flush1(flush1),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .if_id_instr0(if_id_instr0), .if_id_instr1(if_id_instr1),
    .if_id_pc0(if_id_pc0), .if_id_pc1(if_id_pc1),
    .if_id_valid0(if_id_valid0), .if_id_valid1(if_id_valid1),
    .if_id_opcode0(if_id_opcode0), .if_id_opcode1(if_id_opcode1),
    .if_id_rs0(if_id_rs0), .if_id_rs1(if_id_rs1),
    .if_id_rt0(if_id_rt0), .if_id_rt1(if_id_rt1),
    .if_id_rd0(if_id_rd0), .if_id_rd1(if_id_rd1),
    .first(first)
  );

  typedef struct {
    logic        rst, br;
    logic [15:0] tgt;
    logic [3:0]  s0, s1, f0, f1;
    logic [15:0] e_pc, e_pc0, e_pc1;
    logic        e_v0, e_v1, e_first;
    logic [31:0] e_i0, e_i1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic br, logic [15:0] tgt,
                              logic [3:0] s0, logic [3:0] s1, logic [3:0] f0, logic [3:0] f1,
                              logic [15:0] e_pc, logic e_v0, logic [31:0] e_i0, logic [15:0] e_pc0,
                              logic e_v1, logic [31:0] e_i1, logic [15:0] e_pc1, logic e_first);
    vec_t v;
    v.rst = rst; v.br = br; v.tgt = tgt;
    v.s0 = s0; v.s1 = s1; v.f0 = f0; v.f1 = f1;
    v.e_pc = e_pc; v.e_v0 = e_v0; v.e_i0 = e_i0; v.e_pc0 = e_pc0;
    v.e_v1 = e_v1; v.e_i1 = e_i1; v.e_pc1 = e_pc1; v.e_first = e_first;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic br, input logic [15:0] tgt,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] f0, input logic [3:0] f1);
    reset = rst; branch_taken = br; branch_target = tgt;
    stall0 = s0; stall1 = s1; flush0 = f0; flush1 = f1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 16'h0, '0, '0, '0, '0);

    //          rst br  tgt      s0   s1   f0  f1    pc     v0 i0            pc0      v1 i1            pc1      first
    vecs.push_back(mk(1, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0000, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0002, 1, 32'h100,      16'h0000, 1, 32'h101,      16'h0001, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0004, 1, 32'h102,      16'h0002, 1, 32'h103,      16'h0003, 0));
    vecs.push_back(mk(0, 0, 16'h0,    PI,  PI,  '0, '0, 16'h0004, 1, 32'h102,      16'h0002, 1, 32'h103,      16'h0003, 0));
    vecs.push_back(mk(0, 0, 16'h0,    PI,  PI,  '0, '0, 16'h0004, 1, 32'h102,      16'h0002, 1, 32'h103,      16'h0003, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0006, 1, 32'h104,      16'h0004, 1, 32'h105,      16'h0005, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  PI,  IF, '0, 16'h0007, 1, 32'h106,      16'h0006, 1, 32'h105,      16'h0005, 1));
    vecs.push_back(mk(0, 0, 16'h0,    PI,  '0,  '0, IF, 16'h0008, 1, 32'h106,      16'h0006, 1, 32'h107,      16'h0007, 0));
    vecs.push_back(mk(0, 0, 16'h0,    PCB, PCB, '0, '0, 16'h000A, 1, 32'h108,      16'h0008, 1, 32'h109,      16'h0009, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  IF, '0, 16'h000A, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h000C, 1, 32'h10A,      16'h000A, 1, 32'h10B,      16'h000B, 0));
    vecs.push_back(mk(0, 0, 16'h0,    PI,  '0,  '0, '0, 16'h000C, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h000E, 1, 32'h10C,      16'h000C, 1, 32'h10D,      16'h000D, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  PI,  IF, '0, 16'h000F, 1, 32'h10E,      16'h000E, 1, 32'h10D,      16'h000D, 1));
    vecs.push_back(mk(0, 1, 16'h0020, PI,  PI,  '0, '0, 16'h0020, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0022, 1, 32'h120,      16'h0020, 1, 32'h121,      16'h0021, 0));
    vecs.push_back(mk(0, 1, 16'hFFFF, '0,  '0,  '0, '0, 16'hFFFF, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0001, 1, 32'h100FF,    16'hFFFF, 1, 32'h100,      16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'hFFFF, '0,  '0,  '0, '0, 16'hFFFF, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0000, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  '0,  '0, '0, 16'h0002, 1, 32'h100,      16'h0000, 1, 32'h101,      16'h0001, 0));
    vecs.push_back(mk(0, 0, 16'h0,    '0,  PI,  IF, '0, 16'h0003, 1, 32'h102,      16'h0002, 1, 32'h101,      16'h0001, 1));
    vecs.push_back(mk(1, 1, 16'h0040, PI,  PI,  '0, '0, 16'h0000, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'h0030, '0,  '0,  '0, '0, 16'h0030, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0,    PI,  PI,  '0, '0, 16'h0030, 0, NOP,          16'h0000, 0, NOP,          16'h0000, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].br, vecs[i].tgt, vecs[i].s0, vecs[i].s1, vecs[i].f0, vecs[i].f1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i),     {16'h0, pc},           {16'h0, vecs[i].e_pc});
      chk($sformatf("v%0d valid0", i), {31'h0, if_id_valid0}, {31'h0, vecs[i].e_v0});
      chk($sformatf("v%0d valid1", i), {31'h0, if_id_valid1}, {31'h0, vecs[i].e_v1});
      chk($sformatf("v%0d instr0", i), if_id_instr0,          vecs[i].e_i0);
      chk($sformatf("v%0d instr1", i), if_id_instr1,          vecs[i].e_i1);
      chk($sformatf("v%0d pc0", i),    {16'h0, if_id_pc0},    {16'h0, vecs[i].e_pc0});
      chk($sformatf("v%0d pc1", i),    {16'h0, if_id_pc1},    {16'h0, vecs[i].e_pc1});
      chk($sformatf("v%0d first", i),  {31'h0, first},        {31'h0, vecs[i].e_first});
      chk($sformatf("v%0d addr0", i),  {16'h0, bus.imem_addr0}, {16'h0, vecs[i].e_pc});
      chk($sformatf("v%0d addr1", i),  {16'h0, bus.imem_addr1}, {16'h0, vecs[i].e_pc + 16'd1});
      chk($sformatf("v%0d op0", i),    {26'h0, if_id_opcode0}, {26'h0, vecs[i].e_i0[31:26]});
      chk($sformatf("v%0d op1", i),    {26'h0, if_id_opcode1}, {26'h0, vecs[i].e_i1[31:26]});
    end

    // Field decode of real instruction words, then of the empty-slot NOP.
    alt = 1'b1;
    drive(1'b0, 1'b0, 16'h0, '0, '0, '0, '0);
    @(posedge clk);
    #1;
    chk("dec op0", {26'h0, if_id_opcode0}, 32'h23);
    chk("dec rs0", {27'h0, if_id_rs0}, 32'd2);
    chk("dec rt0", {27'h0, if_id_rt0}, 32'd3);
    chk("dec rd0", {27'h0, if_id_rd0}, 32'd5);
    chk("dec op1", {26'h0, if_id_opcode1}, 32'h00);
    chk("dec rs1", {27'h0, if_id_rs1}, 32'd9);
    chk("dec rt1", {27'h0, if_id_rt1}, 32'd8);
    chk("dec rd1", {27'h0, if_id_rd1}, 32'd10);
    chk("dec pc", {16'h0, pc}, 32'h32);

    // Split with slot 1 held keeps the slot-1 fields from the prior pair.
    drive(1'b0, 1'b0, 16'h0, '0, PI, IF, '0);
    @(posedge clk);
    #1;
    chk("split rs1 held", {27'h0, if_id_rs1}, 32'd9);
    chk("split rd0 new", {27'h0, if_id_rd0}, 32'd5);
    chk("split pc0", {16'h0, if_id_pc0}, 32'h32);
    chk("split pc1", {16'h0, if_id_pc1}, 32'h31);
    chk("split first", {31'h0, first}, 32'd1);

    drive(1'b0, 1'b0, 16'h0, '0, '0, '0, IF);
    @(posedge clk);
    #1;
    chk("nop op0", {26'h0, if_id_opcode0}, 32'h3F);
    chk("nop rs0", {27'h0, if_id_rs0}, 32'd0);
    chk("nop rd1", {27'h0, if_id_rd1}, 32'd0);
    chk("nop pc held", {16'h0, pc}, 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
